ysyx_24080014_lsu: RTL and testbench

Load/store unit between the execute stage and the data-memory bus; it produces the `mem_ready` completion pulse and the load write-back data that the register file consumes. Each accepted access is latched, issued as one word-aligned bus transaction over a valid/ready request and response channel, and completed with a one-cycle `mem_ready` pulse. Byte and halfword accesses are aligned on the store side, and extracted and extended on the load side. Misaligned or unsupported accesses complete with a fault and no bus traffic.

---
 rtl/ysyx_24080014_pkg.sv | 21 ++
 rtl/ysyx_24080014_lsu_align.sv | 75 +++++++
 rtl/ysyx_24080014_lsu.sv | 118 +++++++++++
 tb/tb_ysyx_24080014_lsu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080014_pkg.sv
// Shared types and constants for the ysyx_24080014 load/store unit.
// The FSM encoding, funct3 access codes and datapath widths live here.
package ysyx_24080014_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_t;

endpackage

// File: rtl/ysyx_24080014_lsu_align.sv
// Combinational lane logic for the LSU: store replication and byte strobes,
// load shift/extend, and misaligned/illegal access detection.
module ysyx_24080014_lsu_align
  import ysyx_24080014_pkg::*;
(
  input  logic [2:0]        chk_funct3,
  input  logic [1:0]        chk_off,
  input  logic              chk_we,
  output logic              chk_fault,
  input  logic [2:0]        funct3,
  input  logic [1:0]        off,
  input  logic              we,
  input  logic [XLEN-1:0]   store_data,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [XLEN-1:0]   load_ext
);

  logic [XLEN-1:0] shifted;

  // Each byte lane picks its source byte and enable independently.
  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
    always_comb begin
      wdata[8*gi +: 8] = 8'h00;
      wstrb[gi]        = 1'b0;
      if (we) begin
        case (funct3)
          F3_B: begin
            wdata[8*gi +: 8] = store_data[7:0];
            wstrb[gi]        = (off == 2'(gi));
          end
          F3_H: begin
            wdata[8*gi +: 8] = store_data[8*(gi%2) +: 8];
            wstrb[gi]        = (off[1] == 1'(gi/2));
          end
          F3_W: begin
            wdata[8*gi +: 8] = store_data[8*gi +: 8];
            wstrb[gi]        = 1'b1;
          end
          default: begin
            wdata[8*gi +: 8] = 8'h00;
            wstrb[gi]        = 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    shifted  = rdata >> {off, 3'b000};
    load_ext = shifted;
    case (funct3)
      F3_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_ext = {24'h000000, shifted[7:0]};
      F3_HU:   load_ext = {16'h0000, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  // Unsigned variants exist only for loads; unlisted codes always fault.
  always_comb begin
    chk_fault = 1'b0;
    case (chk_funct3)
      F3_B:    chk_fault = 1'b0;
      F3_H:    chk_fault = chk_off[0];
      F3_W:    chk_fault = |chk_off;
      F3_BU:   chk_fault = chk_we;
      F3_HU:   chk_fault = chk_we | chk_off[0];
      default: chk_fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_24080014_lsu.sv
// Load/store unit: latches one access, runs a single word-aligned bus
// transaction and completes it with a one-cycle mem_ready pulse.
module ysyx_24080014_lsu
  import ysyx_24080014_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              ReadWr,
  input  logic              StoreWr,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   store_data,
  output logic              mem_ready,
  output logic [XLEN-1:0]   load_data,
  output logic              lsu_fault,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [STRB_W-1:0] mem_req_wstrb,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  input  logic              mem_rsp_err
);

  lsu_state_t state_reg, state_next;

  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] sd_reg;
  logic [XLEN-1:0] rdata_reg;
  logic [2:0]      funct3_reg;
  logic            we_reg;
  logic            fault_reg;

  logic            accept;
  logic            accept_fault;
  logic            chk_fault;
  logic [XLEN-1:0] load_ext;

  // Both strobes set still counts as an access, but one that faults.
  assign accept       = valid && (ReadWr || StoreWr);
  assign accept_fault = (ReadWr && StoreWr) || chk_fault;

  ysyx_24080014_lsu_align u_align (
    .chk_funct3 (funct3),
    .chk_off    (addr[1:0]),
    .chk_we     (StoreWr),
    .chk_fault  (chk_fault),
    .funct3     (funct3_reg),
    .off        (addr_reg[1:0]),
    .we         (we_reg),
    .store_data (sd_reg),
    .rdata      (rdata_reg),
    .wdata      (mem_req_wdata),
    .wstrb      (mem_req_wstrb),
    .load_ext   (load_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = accept_fault ? ST_DONE : ST_REQ;
      ST_REQ:  if (mem_req_ready) state_next = ST_WAIT;
      ST_WAIT: if (mem_rsp_valid) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg   <= '0;
      sd_reg     <= '0;
      rdata_reg  <= '0;
      funct3_reg <= 3'b000;
      we_reg     <= 1'b0;
      fault_reg  <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && accept) begin
        addr_reg   <= addr;
        sd_reg     <= store_data;
        funct3_reg <= funct3;
        we_reg     <= StoreWr;
        fault_reg  <= accept_fault;
        rdata_reg  <= '0;
      end
      // Responses outside WAIT are dropped on the floor.
      if (state_reg == ST_WAIT && mem_rsp_valid) begin
        rdata_reg <= mem_rsp_rdata;
        fault_reg <= mem_rsp_err;
      end
    end
  end

  always_comb begin
    mem_req_valid = (state_reg == ST_REQ);
    mem_ready     = (state_reg == ST_DONE);
    lsu_fault     = (state_reg == ST_DONE) && fault_reg;
    load_data     = '0;
    if (state_reg == ST_DONE && !we_reg && !fault_reg) begin
      load_data = load_ext;
    end
  end

  assign mem_req_addr = {addr_reg[XLEN-1:2], 2'b00};
  assign mem_req_we   = we_reg;

endmodule

// File: tb/tb_ysyx_24080014_lsu.sv
// Randomized bench for ysyx_24080014_lsu with a built-in bus responder and
// an arithmetic reference model of each access.
module tb_ysyx_24080014_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ReadWr;
  logic        StoreWr;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_ready;
  logic [31:0] load_data;
  logic        lsu_fault;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;

  int n_vec = 0;
  int n_err = 0;
  int n_txn = 0;

  always #5 clk = ~clk;

  ysyx_24080014_lsu dut (
    .clk           (clk),
    .rst           (rst),
    .valid         (valid),
    .ReadWr        (ReadWr),
    .StoreWr       (StoreWr),
    .funct3        (funct3),
    .addr          (addr),
    .store_data    (store_data),
    .mem_ready     (mem_ready),
    .load_data     (load_data),
    .lsu_fault     (lsu_fault),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_err   (mem_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access from the upstream stage, answered by the bench's bus model.
  task automatic do_access(input logic rw, input logic sw, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rd, input logic err,
                           input int rq_st, input int rs_st);
    int          nb;
    int          exp_lat;
    int          rq_cnt;
    int          rs_cnt;
    int          lat;
    logic        pre_fault;
    logic        exp_fault;
    logic        in_wait;
    logic        done;
    logic [1:0]  off;
    logic [31:0] mask;
    logic [31:0] v;
    logic [31:0] exp_ld;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;

    off = a[1:0];
    case (f3[1:0])
      2'd0:    nb = 1;
      2'd1:    nb = 2;
      default: nb = 4;
    endcase
    pre_fault = (rw && sw) || !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
                (sw && f3[2]) || (nb == 2 && a[0]) || (nb == 4 && off != 2'd0);
    mask      = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
    exp_strb  = 4'((((1 << nb) - 1) << off) & 15);
    exp_wdata = (nb == 1) ? {24'h0, sd[7:0]} * 32'h0101_0101 :
                (nb == 2) ? {16'h0, sd[15:0]} * 32'h0001_0001 : sd;
    v = (rd >> (8 * off)) & mask;
    if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
    exp_fault = pre_fault || err;
    exp_ld    = (exp_fault || sw) ? 32'h0 : v;
    exp_lat   = pre_fault ? 1 : 3 + rq_st + rs_st;

    @(negedge clk);
    chk("ready_pulse", {31'h0, mem_ready}, 32'h0);

    if (!rw && !sw) begin
      valid = 1'b1; ReadWr = 1'b0; StoreWr = 1'b0; funct3 = f3; addr = a; store_data = sd;
      repeat (3) begin
        @(negedge clk);
        chk("ignore_req", {31'h0, mem_req_valid}, 32'h0);
        chk("ignore_rdy", {31'h0, mem_ready}, 32'h0);
      end
      valid = 1'b0;
      $display("txn %0d ignored (no strobe) addr=%h", n_txn, a);
      n_txn++;
      return;
    end

    valid = 1'b1; ReadWr = rw; StoreWr = sw; funct3 = f3; addr = a; store_data = sd;
    mem_req_ready = 1'($urandom_range(0, 1));
    mem_rsp_valid = 1'b0;
    rq_cnt = 0; rs_cnt = 0; in_wait = 1'b0; done = 1'b0; lat = 0;

    for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = $urandom;
      mem_rsp_err   = 1'($urandom_range(0, 1));
      if (in_wait) begin
        if (rs_cnt == rs_st) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = rd;
          mem_rsp_err   = err;
          in_wait = 1'b0;
        end
        rs_cnt++;
      end
      if (mem_req_valid) begin
        if (pre_fault) begin
          chk("no_req_on_fault", {31'h0, mem_req_valid}, 32'h0);
        end else begin
          chk("req_addr", mem_req_addr, {a[31:2], 2'b00});
          chk("req_we", {31'h0, mem_req_we}, {31'h0, sw});
          if (sw) begin
            chk("req_wstrb", {28'h0, mem_req_wstrb}, {28'h0, exp_strb});
            chk("req_wdata", mem_req_wdata, exp_wdata);
          end
        end
        if (rq_cnt == rq_st) begin
          mem_req_ready = 1'b1;
          in_wait = 1'b1;
        end
        rq_cnt++;
      end else if (!in_wait) begin
        mem_req_ready = 1'($urandom_range(0, 1));
      end
      if (mem_ready) begin
        lat = cyc;
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("lsu_fault", {31'h0, lsu_fault}, {31'h0, exp_fault});
        chk("load_data", load_data, exp_ld);
        valid = 1'b0; ReadWr = 1'b0; StoreWr = 1'b0;
        mem_req_ready = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin
      chk("timeout", 32'h0, 32'h1);
      valid = 1'b0; ReadWr = 1'b0; StoreWr = 1'b0;
    end
    $display("txn %0d rw=%0d sw=%0d f3=%0d addr=%h sd=%h rd=%h err=%0d lat=%0d fault=%0d ld=%h",
             n_txn, rw, sw, f3, a, sd, rd, err, lat, lsu_fault, load_data);
    n_txn++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; ReadWr = 1'b0; StoreWr = 1'b0; funct3 = 3'b0;
    addr = 32'h0; store_data = 32'h0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0; mem_rsp_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, mem_ready}, 32'h0);
    chk("rst_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_we", {31'h0, mem_req_we}, 32'h0);
    chk("rst_fault", {31'h0, lsu_fault}, 32'h0);
    chk("rst_wstrb", {28'h0, mem_req_wstrb}, 32'h0);
    chk("rst_addr", mem_req_addr, 32'h0);
    chk("rst_wdata", mem_req_wdata, 32'h0);
    chk("rst_load", load_data, 32'h0);
    rst = 1'b0;

    // Directed accesses from the plan.
    do_access(1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 0);
    do_access(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_0000, 1'b0, 0, 0);
    do_access(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_0000, 1'b0, 0, 0);
    do_access(1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'h80FF_0000, 1'b0, 0, 0);
    do_access(1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 32'h0, 1'b0, 0, 0);
    do_access(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_56AB, 32'h0, 1'b0, 0, 0);
    do_access(1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h1111_2222, 1'b0, 0, 0);
    do_access(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h5555_AAAA, 1'b1, 3, 2);
    do_access(1'b1, 1'b1, 3'b010, 32'h8000_0020, 32'h0, 32'h0, 1'b0, 0, 0);
    do_access(1'b0, 1'b1, 3'b100, 32'h8000_0020, 32'h0, 32'h0, 1'b0, 0, 0);

    // Reset while waiting for a response, then a stray response.
    @(negedge clk);
    valid = 1'b1; ReadWr = 1'b1; StoreWr = 1'b0; funct3 = 3'b010; addr = 32'h0000_0100;
    mem_req_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", {31'h0, mem_req_valid}, 32'h1);
    valid = 1'b0; ReadWr = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_req_drop", {31'h0, mem_req_valid}, 32'h0);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBAD0_BAD0; mem_rsp_err = 1'b1;
    repeat (3) begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      chk("mid_rst_no_ready", {31'h0, mem_ready}, 32'h0);
      chk("mid_rst_no_req", {31'h0, mem_req_valid}, 32'h0);
    end
    do_access(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 0);

    // Randomized traffic.
    for (int t = 0; t < 250; t++) begin
      int          op;
      logic        rw;
      logic        sw;
      logic [2:0]  f3;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      rw = (op < 4) || (op == 8);
      sw = (op >= 4 && op < 8) || (op == 8);
      if ($urandom_range(0, 4) != 0) begin
        case ($urandom_range(0, 4))
          0:       f3 = 3'b000;
          1:       f3 = 3'b001;
          2:       f3 = 3'b010;
          3:       f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 7));
      end
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
      do_access(rw, sw, f3, a, $urandom, $urandom, ($urandom_range(0, 7) == 0),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
